// File: rtl/counter_bn.sv
// counter_bn: wide up/down/step/load counter with a wrap/clamp flag, a load
// flag and a saturating count of wrap events. One register stage; every
// output is registered and reflects the inputs sampled on the previous edge.
module counter_bn #(
  parameter int WIDTH    = 32,
  parameter int STEP_DN  = 3,
  parameter bit SATURATE = 1'b0,
  parameter int WCNT_W   = 8
) (
  input  logic              bn_clk,
  input  logic              bn_reset,
  input  logic              bn_enable,
  input  logic [1:0]        bn_mode,
  input  logic [WIDTH-1:0]  bn_D,
  input  logic              bn_wclr,
  output logic [WIDTH-1:0]  bn_Q,
  output logic              bn_rco,
  output logic              bn_load,
  output logic [WCNT_W-1:0] bn_wraps
);

  typedef enum logic [1:0] {
    MODE_UP   = 2'b00,
    MODE_DN   = 2'b01,
    MODE_STEP = 2'b10,
    MODE_LOAD = 2'b11
  } mode_e;

  localparam logic [WIDTH-1:0]  Q_MAX    = '1;
  localparam logic [WIDTH-1:0]  Q_ZERO   = '0;
  localparam logic [WIDTH-1:0]  STEP_W   = WIDTH'(STEP_DN);
  localparam logic [WIDTH-1:0]  ONE_W    = WIDTH'(1);
  localparam logic [WCNT_W-1:0] WRAP_MAX = '1;

  // Full-width add with the carry kept in the extra top bit.
  function automatic logic [WIDTH:0] add_carry(input logic [WIDTH-1:0] a,
                                               input logic [WIDTH-1:0] b);
    return {1'b0, a} + {1'b0, b};
  endfunction

  // Full-width subtract with the borrow kept in the extra top bit.
  function automatic logic [WIDTH:0] sub_borrow(input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
    return {1'b0, a} - {1'b0, b};
  endfunction

  // Overflowed sum: either the modulo result or a clamp at the top.
  function automatic logic [WIDTH-1:0] sat_up(input logic [WIDTH:0] sum);
    if (sum[WIDTH] && SATURATE)
      return Q_MAX;
    return sum[WIDTH-1:0];
  endfunction

  // Underflowed difference: either the modulo result or a clamp at zero.
  function automatic logic [WIDTH-1:0] sat_dn(input logic [WIDTH:0] diff);
    if (diff[WIDTH] && SATURATE)
      return Q_ZERO;
    return diff[WIDTH-1:0];
  endfunction

  // Wrap-event counter sticks at its all-ones value instead of rolling over.
  function automatic logic [WCNT_W-1:0] wraps_inc(input logic [WCNT_W-1:0] w);
    if (w == WRAP_MAX)
      return w;
    return w + 1'b1;
  endfunction

  logic [WIDTH-1:0]  q_p1;
  logic              rco_p1;
  logic              load_p1;
  logic [WCNT_W-1:0] wraps_p1;

  logic [WIDTH-1:0]  q_p0;
  logic              rco_p0;
  logic              load_p0;
  logic [WCNT_W-1:0] wraps_p0;

  logic [WIDTH:0]    up_sum;
  logic [WIDTH:0]    dn_diff;
  logic [WIDTH:0]    step_diff;
  mode_e             mode;

  assign mode      = mode_e'(bn_mode);
  assign up_sum    = add_carry(q_p1, ONE_W);
  assign dn_diff   = sub_borrow(q_p1, ONE_W);
  assign step_diff = sub_borrow(q_p1, STEP_W);

  // Next count and flags; the carry/borrow bit is exactly the wrap condition.
  always_comb begin
    q_p0    = q_p1;
    rco_p0  = 1'b0;
    load_p0 = 1'b0;
    if (bn_enable) begin
      case (mode)
        MODE_UP: begin
          q_p0   = sat_up(up_sum);
          rco_p0 = up_sum[WIDTH];
        end
        MODE_DN: begin
          q_p0   = sat_dn(dn_diff);
          rco_p0 = dn_diff[WIDTH];
        end
        MODE_STEP: begin
          q_p0   = sat_dn(step_diff);
          rco_p0 = step_diff[WIDTH];
        end
        default: begin
          q_p0    = bn_D;
          load_p0 = 1'b1;
        end
      endcase
    end
  end

  // Next wrap count: clear wins over an increment on the same edge.
  always_comb begin
    wraps_p0 = wraps_p1;
    if (bn_wclr)
      wraps_p0 = '0;
    else if (rco_p0)
      wraps_p0 = wraps_inc(wraps_p1);
  end

  // ---- stage boundary: all state registered here ----
  // State register; reset clears everything immediately, independent of clock.
  always_ff @(posedge bn_clk or posedge bn_reset) begin
    if (bn_reset) begin
      q_p1     <= '0;
      rco_p1   <= 1'b0;
      load_p1  <= 1'b0;
      wraps_p1 <= '0;
    end else begin
      q_p1     <= q_p0;
      rco_p1   <= rco_p0;
      load_p1  <= load_p0;
      wraps_p1 <= wraps_p0;
    end
  end

  assign bn_Q     = q_p1;
  assign bn_rco   = rco_p1;
  assign bn_load  = load_p1;
  assign bn_wraps = wraps_p1;

endmodule
